// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and issues instruction-memory
// fetch requests with a req/ack handshake. Hazard stalls gate the issue of
// new requests, and branch/jump redirects are applied either immediately
// (when no request is outstanding, or on the ack cycle) or remembered and
// applied when the outstanding request completes.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic        instr_valid,
  output logic [31:0] instr_pc
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_pc_q, instr_pc_d;

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      redir_pend_q  <= 1'b0;
      redir_tgt_q   <= 32'd0;
      instr_valid_q <= 1'b0;
      instr_pc_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redir_pend_q  <= redir_pend_d;
      redir_tgt_q   <= redir_tgt_d;
      instr_valid_q <= instr_valid_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  // Next-state logic: sequencing, redirect capture and PC advance.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redir_pend_d  = redir_pend_q;
    redir_tgt_d   = redir_tgt_q;
    instr_valid_d = 1'b0;
    instr_pc_d    = instr_pc_q;

    case (state_q)
      BOOT: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
        end else begin
          pc_d = pc_q;
        end
        if (stall) begin
          state_d = HOLD;
        end else begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (!imem_ack) begin
          // Request outstanding: address must stay stable, so a redirect is
          // only remembered (latest one wins) until the ack arrives.
          if (redirect_valid) begin
            redir_pend_d = 1'b1;
            redir_tgt_d  = redirect_target;
          end else begin
            redir_pend_d = redir_pend_q;
          end
        end else begin
          if (redirect_valid || redir_pend_q) begin
            // Fetched instruction is on the wrong path; drop it.
            redir_pend_d = 1'b0;
            if (redirect_valid) begin
              pc_d = redirect_target;
            end else begin
              pc_d = redir_tgt_q;
            end
          end else begin
            pc_d          = pc_q + PC_STEP;
            instr_valid_d = 1'b1;
            instr_pc_d    = pc_q;
          end
          // Stall only takes effect once the current request has completed.
          if (stall) begin
            state_d = HOLD;
          end else begin
            state_d = FETCH;
          end
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
        end else begin
          pc_d = pc_q;
        end
        if (!stall) begin
          state_d = FETCH;
        end else begin
          state_d = HOLD;
        end
      end

      default: begin
        state_d      = BOOT;
        pc_d         = RESET_PC;
        redir_pend_d = 1'b0;
      end
    endcase
  end

  // The request is a pure decode of the state register, so an async reset
  // withdraws it immediately.
  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic        instr_valid;
  logic [31:0] instr_pc;

  int total_checks;
  int passed_checks;

  pc_sequencer #(
    .RESET_PC(32'd0),
    .PC_STEP (32'd1)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_ack       (imem_ack),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .pc             (pc),
    .instr_valid    (instr_valid),
    .instr_pc       (instr_pc)
  );

  // 10 time-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one rising edge and sample 2 units after it.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Check request, address and valid flags in one go.
  task automatic chk_fetch(input string tag, input logic req, input logic [31:0] addr,
                           input logic iv);
    chk({tag, ".req"},  {31'd0, imem_req}, {31'd0, req});
    chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".pc"},   pc, addr);
    chk({tag, ".iv"},   {31'd0, instr_valid}, {31'd0, iv});
  endtask

  initial begin
    total_checks    = 0;
    passed_checks   = 0;
    reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    imem_ack        = 1'b0;

    // Reset state
    tick();
    tick();
    chk_fetch("rst", 1'b0, 32'd0, 1'b0);
    chk("rst.ipc", instr_pc, 32'd0);

    // Zero-wait memory: one instruction per cycle
    imem_ack = 1'b1;
    reset    = 1'b0;
    chk("boot.req", {31'd0, imem_req}, 32'd0);
    tick(); chk_fetch("zw1", 1'b1, 32'd0, 1'b0);
    tick(); chk_fetch("zw2", 1'b1, 32'd1, 1'b1); chk("zw2.ipc", instr_pc, 32'd0);
    tick(); chk_fetch("zw3", 1'b1, 32'd2, 1'b1); chk("zw3.ipc", instr_pc, 32'd1);
    tick(); chk_fetch("zw4", 1'b1, 32'd3, 1'b1); chk("zw4.ipc", instr_pc, 32'd2);
    tick(); chk_fetch("zw5", 1'b1, 32'd4, 1'b1);
    tick(); chk_fetch("zw6", 1'b1, 32'd5, 1'b1); chk("zw6.ipc", instr_pc, 32'd4);

    // Ack delayed: addr 5 held for 3 cycles
    imem_ack = 1'b0;
    tick(); chk_fetch("wait1", 1'b1, 32'd5, 1'b0);
    tick(); chk_fetch("wait2", 1'b1, 32'd5, 1'b0);
    imem_ack = 1'b1;
    tick(); chk_fetch("wait_ack", 1'b1, 32'd6, 1'b1); chk("wait_ack.ipc", instr_pc, 32'd5);
    imem_ack = 1'b0;
    tick(); chk_fetch("wait6", 1'b1, 32'd6, 1'b0);

    // Redirect to 0x40 during a wait, ack two cycles later
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    tick(); chk_fetch("rdw1", 1'b1, 32'd6, 1'b0);
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    tick(); chk_fetch("rdw2", 1'b1, 32'd6, 1'b0);
    imem_ack = 1'b1;
    tick(); chk_fetch("rdw_ack", 1'b1, 32'h40, 1'b0);
    imem_ack = 1'b0;

    // Two pending redirects: later (0x80) wins
    redirect_valid  = 1'b1;
    redirect_target = 32'h50;
    tick();
    redirect_target = 32'h80;
    tick(); chk_fetch("rd2_wait", 1'b1, 32'h40, 1'b0);
    redirect_valid = 1'b0;
    imem_ack       = 1'b1;
    tick(); chk_fetch("rd2_ack", 1'b1, 32'h80, 1'b0);

    // Pending 0x90 vs live redirect 0xA0 on ack: live wins
    imem_ack        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h90;
    tick();
    imem_ack        = 1'b1;
    redirect_target = 32'hA0;
    tick(); chk_fetch("live_win", 1'b1, 32'hA0, 1'b0);
    redirect_valid  = 1'b0;

    // Stall on ack: go idle, pc frozen for 4 cycles
    stall = 1'b1;
    tick(); chk_fetch("st_ack", 1'b0, 32'hA1, 1'b1); chk("st_ack.ipc", instr_pc, 32'hA0);
    imem_ack = 1'b0;
    tick(); chk_fetch("st1", 1'b0, 32'hA1, 1'b0);
    tick(); chk_fetch("st2", 1'b0, 32'hA1, 1'b0);
    tick(); chk_fetch("st3", 1'b0, 32'hA1, 1'b0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h10;
    tick(); chk_fetch("hold_rd", 1'b0, 32'h10, 1'b0);
    redirect_valid = 1'b0;
    stall          = 1'b0;
    tick(); chk_fetch("hold_rel", 1'b1, 32'h10, 1'b0);

    // Redirect + stall on an ack cycle; forces pc to 0xFFFFFFFF
    imem_ack        = 1'b1;
    stall           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFF;
    tick(); chk_fetch("rd_st_ack", 1'b0, 32'hFFFF_FFFF, 1'b0);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    imem_ack       = 1'b0;
    tick(); chk_fetch("wrap_req", 1'b1, 32'hFFFF_FFFF, 1'b0);
    imem_ack = 1'b1;
    tick(); chk_fetch("wrap", 1'b1, 32'h0, 1'b1); chk("wrap.ipc", instr_pc, 32'hFFFF_FFFF);

    // Stall rising during an outstanding request is ignored
    imem_ack = 1'b0;
    stall    = 1'b1;
    tick(); chk_fetch("st_ign", 1'b1, 32'h0, 1'b0);
    stall    = 1'b0;

    // Reset mid-request after a valid instruction
    imem_ack = 1'b1;
    tick(); chk_fetch("pre_rst", 1'b1, 32'd1, 1'b1);
    imem_ack = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk_fetch("async_rst", 1'b0, 32'd0, 1'b0);
    chk("async_rst.ipc", instr_pc, 32'd0);
    tick(); chk_fetch("rst_hold", 1'b0, 32'd0, 1'b0);
    reset = 1'b0;
    chk("restart_boot.req", {31'd0, imem_req}, 32'd0);
    tick(); chk_fetch("restart", 1'b1, 32'd0, 1'b0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
